inv_s_box_ram: RTL
==================

# inv_s_box_ram

Inverse AES S-box table that builds itself from the forward S-box load stream. It accepts the same byte-per-cycle write stream that loads `s_box_rom`: write data is the forward S-box value and write address is the forward index. It stores the inverse mapping, `inv[in] = addr0`. After all 256 distinct entries are captured it serves four registered read ports in parallel for the InvSubBytes datapath of the AES-128 decryptor.

## Interface
- No parameters; data width fixed at 8 bits, depth 256.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous table clear; restarts the load phase.
- `wr_en`  in  1  write strobe for one forward S-box entry.
- `in`  in  8  forward S-box value `S[addr0]`.
- `rd_en`  in  1  read strobe for all four ports.
- `addr0`  in  8  forward index during writes; read address for port 0 during reads.
- `addr1`, `addr2`, `addr3`  in  8  read addresses for ports 1 to 3.
- `out0`, `out1`, `out2`, `out3`  out  8  registered inverse values `inv[addrN]`.
- `rd_valid`  out  1  the out0 to out3 values come from a read accepted on the previous cycle.
- `ready`  out  1  table complete: 256 unique values captured.
- `err_dup`  out  1  sticky: the same `in` value was written twice during load.
- `count`  out  9  number of unique entries captured, 0 to 256.

## Operation
- State machine with three states:
  - **LOAD** (state after reset or `clr`).
  - **READY**.
  - **ERROR**.
- Internal storage:
  - `mem[256]` of 8 bits.
  - `seen[256]` of 1 bit.
  - `count` of 9 bits.
- **LOAD**, on `wr_en`:
  - If `seen[in]` is 0: `mem[in] <= addr0`, `seen[in] <= 1`, `count <= count+1`.
  - If `seen[in]` is 1: `mem` is unchanged, `err_dup <= 1`, and the state goes to ERROR.
- **LOAD to READY** on the cycle the write that makes `count` equal 256 is accepted. `ready` rises on the following edge.
- **READY**:
  - `wr_en` is ignored; the table is locked.
  - `rd_en` reads `mem[addr0..3]` into `out0..3` and sets `rd_valid` to 1 for one cycle.
- **ERROR**: `wr_en` and `rd_en` are both ignored. The block leaves ERROR only via `clr` or `rst`.
- `rd_en` in LOAD or ERROR: `out0..3` hold their previous values and `rd_valid` is 0.
- `wr_en` and `rd_en` in the same cycle:
  - In LOAD, the write wins and the read is dropped.
  - In READY, the read is performed and the write is ignored.
- `clr` has priority over `wr_en` and `rd_en`:
  - Clears `seen`, `count`, `ready`, `err_dup` and `rd_valid`.
  - Does not clear `mem` contents or `out0..3`.
  - Next state is LOAD.
- `count` saturates at 256 and never wraps.

## Timing
- Reset values (asynchronous on `rst` falling):
  - State LOAD.
  - `out0..3` = 8'h00.
  - `rd_valid` = 0, `ready` = 0, `err_dup` = 0, `count` = 0.
  - `seen` all 0.
- `mem` has no reset.
- Write latency:
  - Entry stored at the edge where `wr_en` is sampled high.
  - `count` updates at that same edge.
- Read latency is one cycle: addresses sampled at edge N, data and `rd_valid` valid after edge N, used at edge N+1.
- Back-to-back reads every cycle are supported at full throughput.
- Reading the same address on several ports in one cycle returns identical data on each of those ports.
- `rst` asserted mid-load discards all progress. After release the block requires a full 256-entry reload.
- Release of `rst` may be asynchronous to `clk`. No output may glitch during reset; all outputs hold their reset values while `rst` is low.

## Test plan
- **Full load**:
  - Stimulus: stream the standard forward S-box with `addr0` 0 to 255, one entry per cycle.
  - Response: `count` reaches 256 and `ready` is 1 one cycle after the last write.
  - Response: `err_dup` is 0.
- **Four-port read**: after the full load, `rd_en` with addr0..3 = b0, 54, bb, 16.
  - Next cycle: `out0..3` = fc, fd, fe, ff and `rd_valid` = 1.
  - Then addr0..3 = 63, 00, ed, 7c gives out0..3 = 00, 52, 53, 01.
- **Duplicate write**: load 0x63 at index 0x00, then 0x63 again at index 0x01.
  - Response: `err_dup` = 1, state ERROR, `count` = 1.
  - A following `rd_en` gives `rd_valid` = 0.
  - `clr` returns `count` to 0 and `err_dup` to 0.
- **Reads during LOAD and locked writes**:
  - Stimulus: `rd_en` with `wr_en` high at `count` = 10.
  - Response: the write is stored, `count` = 11, `rd_valid` = 0.
  - After READY, `wr_en` with in = 0x63 and addr0 = 0x55 leaves `inv[0x63]` = 0x00.
- **Reset mid-load**: pull `rst` low at `count` = 128, then release.
  - Response: `count` = 0, `ready` = 0, `out0..3` = 00.
  - A full reload reaches READY again.
- **Clear and reload**:
  - Stimulus: `clr` in READY.
  - Response: `ready` = 0 and `count` = 0 on the next edge.
  - A reload with an identical stream yields identical read results.

Source files
------------

// File: rtl/inv_s_box_ram.sv
// Inverse AES S-box table.
// Builds inv[S[a]] = a from the forward S-box load stream, then serves four
// registered read ports for the InvSubBytes datapath.
module inv_s_box_ram (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] in,
    input  logic       rd_en,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] addr2,
    input  logic [7:0] addr3,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic       rd_valid,
    output logic       ready,
    output logic       err_dup,
    output logic [8:0] count
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READY = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_mem [256];
    logic [255:0] r_seen;
    logic [8:0] r_count;
    logic       r_ready;
    logic       r_err_dup;
    logic       r_rd_valid;
    logic [7:0] r_out0, r_out1, r_out2, r_out3;

    // Write is only considered while loading; clr overrides everything.
    logic       w_wr_accept;
    logic       w_seen_hit;
    logic       w_store;
    logic       w_dup;
    logic       w_last;
    logic       w_rd_accept;

    assign w_wr_accept = (r_state == S_LOAD) && wr_en && !clr;
    assign w_seen_hit  = r_seen[in];
    assign w_store     = w_wr_accept && !w_seen_hit;
    assign w_dup       = w_wr_accept && w_seen_hit;
    assign w_last      = w_store && (r_count == 9'd255);
    // In LOAD a simultaneous write wins, which falls out of reads being
    // accepted only in READY.
    assign w_rd_accept = (r_state == S_READY) && rd_en && !clr;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) r_state <= S_LOAD;
        else      r_state <= w_next_state;
    end

    // Next-state logic: clr restarts loading, a duplicate locks into ERROR,
    // the 256th unique write moves to READY.
    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned
        // (which would infer a latch).
        w_next_state = r_state;
        if (clr) begin
            w_next_state = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_dup)       w_next_state = S_ERROR;
                    else if (w_last) w_next_state = S_READY;
                end
                S_READY: w_next_state = S_READY;
                S_ERROR: w_next_state = S_ERROR;
                default: w_next_state = S_LOAD;
            endcase
        end
    end

    // Table storage: inverse value written at the forward value's slot.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately left without reset; validity is
        // tracked by r_seen/r_count, so resetting 2 Kbit of RAM buys nothing.
        if (w_store) r_mem[in] <= addr0;
    end

    // Capture tracking: seen bitmap and saturating unique-entry count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seen  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_seen  <= '0;
            r_count <= '0;
        end else if (w_store) begin
            r_seen[in] <= 1'b1;
            if (r_count != 9'd256) r_count <= r_count + 9'd1;
        end
    end

    // Status flags: ready follows the READY state, err_dup is sticky until clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready    <= 1'b0;
            r_err_dup  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_ready    <= (w_next_state == S_READY);
            r_rd_valid <= w_rd_accept;
            if (clr)        r_err_dup <= 1'b0;
            else if (w_dup) r_err_dup <= 1'b1;
        end
    end

    // Four registered read ports; hold their value when no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out0 <= 8'h00;
            r_out1 <= 8'h00;
            r_out2 <= 8'h00;
            r_out3 <= 8'h00;
        end else if (w_rd_accept) begin
            r_out0 <= r_mem[addr0];
            r_out1 <= r_mem[addr1];
            r_out2 <= r_mem[addr2];
            r_out3 <= r_mem[addr3];
        end
    end

    assign out0     = r_out0;
    assign out1     = r_out1;
    assign out2     = r_out2;
    assign out3     = r_out3;
    assign rd_valid = r_rd_valid;
    assign ready    = r_ready;
    assign err_dup  = r_err_dup;
    assign count    = r_count;

endmodule
